// File: rtl/grant_arbiter_4.sv
// Four-way round-robin grant arbiter with a per-grant hold limit.
// Every output is registered. A one-cycle gap follows each grant before the next arbitration.
module grant_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt_n,
    output logic [1:0] gnt_id,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_r, state_nxt_s;
    logic [1:0] last_r, last_nxt_s;
    logic [7:0] hold_cnt_r, hold_cnt_nxt_s;
    logic [3:0] gnt_n_r, gnt_n_nxt_s;
    logic [1:0] gnt_id_r, gnt_id_nxt_s;
    logic       busy_r, busy_nxt_s;
    logic       timeout_r, timeout_nxt_s;
    logic [1:0] winner_s;

    // The search starts just after the previous winner, so that requester gets lowest priority.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] pick;
        logic [1:0] cand;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && r[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [3:0] decode_n(input logic [1:0] id);
        return ~(4'b0001 << id);
    endfunction

    assign winner_s = rr_pick(req, last_r);

    // State and registered-output storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            last_r     <= 2'b11;
            hold_cnt_r <= 8'd0;
            gnt_n_r    <= 4'b1111;
            gnt_id_r   <= 2'b00;
            busy_r     <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            last_r     <= last_nxt_s;
            hold_cnt_r <= hold_cnt_nxt_s;
            gnt_n_r    <= gnt_n_nxt_s;
            gnt_id_r   <= gnt_id_nxt_s;
            busy_r     <= busy_nxt_s;
            timeout_r  <= timeout_nxt_s;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req != 4'b0000) begin
                    state_nxt_s = ST_GRANT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                if (!req[gnt_id_r] || (hold_cnt_r == HOLD_LAST)) begin
                    state_nxt_s = ST_GAP;
                end else begin
                    state_nxt_s = ST_GRANT;
                end
            end
            ST_GAP:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and hold counter.
    always_comb begin
        last_nxt_s     = last_r;
        hold_cnt_nxt_s = hold_cnt_r;
        gnt_id_nxt_s   = gnt_id_r;
        gnt_n_nxt_s    = 4'b1111;
        busy_nxt_s     = 1'b0;
        timeout_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req != 4'b0000) begin
                    last_nxt_s     = winner_s;
                    gnt_id_nxt_s   = winner_s;
                    gnt_n_nxt_s    = decode_n(winner_s);
                    busy_nxt_s     = 1'b1;
                    hold_cnt_nxt_s = 8'd0;
                end else begin
                    busy_nxt_s = 1'b0;
                end
            end
            ST_GRANT: begin
                // A dropped request takes precedence over the limit, so no timeout is flagged.
                if (!req[gnt_id_r]) begin
                    timeout_nxt_s = 1'b0;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    timeout_nxt_s = 1'b1;
                end else begin
                    hold_cnt_nxt_s = hold_cnt_r + 8'd1;
                    gnt_n_nxt_s    = gnt_n_r;
                    busy_nxt_s     = 1'b1;
                end
            end
            ST_GAP: begin
                busy_nxt_s = 1'b0;
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    assign gnt_n   = gnt_n_r;
    assign gnt_id  = gnt_id_r;
    assign busy    = busy_r;
    assign timeout = timeout_r;

endmodule

// File: tb/tb_grant_arbiter_4.sv
// Scoreboard bench for grant_arbiter_4: MAX_HOLD=8 and MAX_HOLD=1 instances run side by side.
module tb_grant_arbiter_4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_a = 4'b0000;
    logic [3:0] req_b = 4'b0000;
    logic [3:0] gnt_n_a, gnt_n_b;
    logic [1:0] gnt_id_a, gnt_id_b;
    logic       busy_a, busy_b, timeout_a, timeout_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    grant_arbiter_4 #(.MAX_HOLD(8)) dut_a (
        .clk(clk), .rst(rst), .req(req_a),
        .gnt_n(gnt_n_a), .gnt_id(gnt_id_a), .busy(busy_a), .timeout(timeout_a)
    );

    grant_arbiter_4 #(.MAX_HOLD(1)) dut_b (
        .clk(clk), .rst(rst), .req(req_b),
        .gnt_n(gnt_n_b), .gnt_id(gnt_id_b), .busy(busy_b), .timeout(timeout_b)
    );

    // Behavioural reference; held counts the cycles the grant has been visible.
    typedef struct {
        int         st;
        logic [1:0] last;
        int         held;
        logic [3:0] gnt_n;
        logic [1:0] id;
        logic       busy;
        logic       to;
    } mdl_t;

    mdl_t m_a, m_b;
    mdl_t q_a[$];
    mdl_t q_b[$];

    function automatic mdl_t mdl_step(input mdl_t m, input logic [3:0] r, input logic rs, input int maxh);
        mdl_t n;
        int   w;
        int   idx;
        n    = m;
        n.to = 1'b0;
        if (rs) begin
            n.st = 0; n.last = 2'b11; n.held = 0; n.gnt_n = 4'b1111;
            n.id = 2'b00; n.busy = 1'b0;
        end else if (m.st == 0) begin
            if (r != 4'b0000) begin
                w = -1;
                for (int k = 1; k <= 4; k++) begin
                    idx = (int'(m.last) + k) % 4;
                    if (w < 0 && r[idx]) w = idx;
                end
                n.st = 1; n.held = 1; n.busy = 1'b1;
                n.id = w[1:0]; n.last = w[1:0];
                n.gnt_n = 4'b1111;
                n.gnt_n[w] = 1'b0;
            end
        end else if (m.st == 1) begin
            if (!r[m.id]) begin
                n.st = 2; n.busy = 1'b0; n.gnt_n = 4'b1111;
            end else if (m.held == maxh) begin
                n.st = 2; n.busy = 1'b0; n.gnt_n = 4'b1111; n.to = 1'b1;
            end else begin
                n.held = m.held + 1;
            end
        end else begin
            n.st = 0;
        end
        return n;
    endfunction

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the expectation, then compare after the edge.
    task automatic tick(input logic [3:0] ra, input logic [3:0] rb, input logic rs);
        mdl_t ea, eb;
        @(negedge clk);
        req_a = ra;
        req_b = rb;
        rst   = rs;
        m_a = mdl_step(m_a, ra, rs, 8);
        m_b = mdl_step(m_b, rb, rs, 1);
        q_a.push_back(m_a);
        q_b.push_back(m_b);
        @(posedge clk);
        #1;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        check_value("a.gnt_n",   32'(gnt_n_a),   32'(ea.gnt_n));
        check_value("a.gnt_id",  32'(gnt_id_a),  32'(ea.id));
        check_value("a.busy",    32'(busy_a),    32'(ea.busy));
        check_value("a.timeout", 32'(timeout_a), 32'(ea.to));
        check_value("b.gnt_n",   32'(gnt_n_b),   32'(eb.gnt_n));
        check_value("b.gnt_id",  32'(gnt_id_b),  32'(eb.id));
        check_value("b.busy",    32'(busy_b),    32'(eb.busy));
        check_value("b.timeout", 32'(timeout_b), 32'(eb.to));
    endtask

    initial begin
        m_a = mdl_step(m_a, 4'b0000, 1'b1, 8);
        m_b = mdl_step(m_b, 4'b0000, 1'b1, 1);

        for (int i = 0; i < 3; i++) tick(4'b0000, 4'b0001, 1'b1);
        check_value("reset.gnt_n", 32'(gnt_n_a), 32'hF);
        check_value("reset.gnt_id", 32'(gnt_id_a), 32'h0);

        // Requesters 1 and 3 after reset: requester 1 wins one cycle later.
        tick(4'b1010, 4'b0001, 1'b0);
        check_value("first.gnt_n", 32'(gnt_n_a), 32'hD);
        check_value("first.gnt_id", 32'(gnt_id_a), 32'h1);
        check_value("first.busy", 32'(busy_a), 32'h1);
        for (int i = 0; i < 4; i++) tick(4'b1010, 4'b0001, 1'b0);
        for (int i = 0; i < 4; i++) tick(4'b0000, 4'b0001, 1'b0);

        // All four requesting: rotation with timeouts on both instances.
        tick(4'b0000, 4'b0001, 1'b1);
        for (int i = 0; i < 56; i++) tick(4'b1111, 4'b0001, 1'b0);

        // Requester 2 releases after a few cycles; next grant needs two dead cycles.
        tick(4'b0000, 4'b0001, 1'b1);
        for (int i = 0; i < 4; i++) tick(4'b0100, 4'b0001, 1'b0);
        check_value("rel.gnt_id", 32'(gnt_id_a), 32'h2);
        tick(4'b0000, 4'b0001, 1'b0);
        check_value("rel.gnt_n", 32'(gnt_n_a), 32'hF);
        check_value("rel.timeout", 32'(timeout_a), 32'h0);
        tick(4'b0100, 4'b0001, 1'b0);
        check_value("rel.gap", 32'(busy_a), 32'h0);
        tick(4'b0100, 4'b0001, 1'b0);
        check_value("rel.regrant", 32'(busy_a), 32'h1);
        tick(4'b0000, 4'b0001, 1'b0);
        for (int i = 0; i < 3; i++) tick(4'b0000, 4'b0001, 1'b0);

        // Request drops exactly at the hold limit: plain release.
        for (int i = 0; i < 8; i++) tick(4'b0001, 4'b0001, 1'b0);
        tick(4'b0000, 4'b0001, 1'b0);
        check_value("limit_drop.timeout", 32'(timeout_a), 32'h0);
        check_value("limit_drop.busy", 32'(busy_a), 32'h0);
        for (int i = 0; i < 3; i++) tick(4'b0000, 4'b0001, 1'b0);

        // Reset in the middle of a grant, then 0 beats 2.
        for (int i = 0; i < 3; i++) tick(4'b0100, 4'b0001, 1'b0);
        tick(4'b0100, 4'b0001, 1'b1);
        check_value("rst_mid.gnt_n", 32'(gnt_n_a), 32'hF);
        check_value("rst_mid.busy", 32'(busy_a), 32'h0);
        check_value("rst_mid.timeout", 32'(timeout_a), 32'h0);
        tick(4'b0101, 4'b0001, 1'b0);
        check_value("rst_mid.winner", 32'(gnt_id_a), 32'h0);
        for (int i = 0; i < 6; i++) tick(4'b0101, 4'b0001, 1'b0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 250; i++) begin
            tick(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 39) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
